// File: rtl/cnn_layer_accel_octo_streamer.sv
// Streams one layer command into the octo: seq_len sequencer words, then rows*cols
// pixel words, popped from a FWFT source through a one-entry tagged output register.
module cnn_layer_accel_octo_streamer #(
    parameter  int C_PIXEL_WIDTH    = 18,
    parameter  int C_SEQ_DATA_WIDTH = 13,
    parameter  int C_BRAM_DEPTH     = 1024,
    localparam int C_SEQ_LEN_WIDTH  = $clog2(C_BRAM_DEPTH / 2 * 5) + 1,
    localparam int C_DIM_WIDTH      = $clog2(C_BRAM_DEPTH) - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_rdy,
    input  logic [C_SEQ_LEN_WIDTH-1:0] cmd_seq_len,
    input  logic [C_DIM_WIDTH-1:0]     cmd_num_rows,
    input  logic [C_DIM_WIDTH-1:0]     cmd_num_cols,
    input  logic [C_PIXEL_WIDTH-1:0]   src_data,
    input  logic                       src_valid,
    output logic                       src_rden,
    output logic [C_PIXEL_WIDTH-1:0]   datain,
    output logic                       datain_valid,
    output logic                       seq_datain_tag,
    output logic                       pixel_datain_tag,
    input  logic                       seq_datain_rdy,
    input  logic                       pixel_datain_rdy,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_SEQ   = 5'b00010,
        ST_PIX   = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

    state_t                      state_q;
    logic [C_SEQ_LEN_WIDTH-1:0]  seq_len_q;
    logic [C_DIM_WIDTH-1:0]      rows_q;
    logic [C_DIM_WIDTH-1:0]      cols_q;
    logic                        pix_nz_q;
    logic [C_SEQ_LEN_WIDTH-1:0]  seq_cnt_q;
    logic [C_DIM_WIDTH-1:0]      row_cnt_q;
    logic [C_DIM_WIDTH-1:0]      col_cnt_q;
    logic [C_PIXEL_WIDTH-1:0]    datain_q;
    logic                        dv_q;
    logic                        seq_tag_q;
    logic                        pix_tag_q;

    logic transfer;
    logic fetch_st;
    logic pop;
    logic seq_last;
    logic col_last;
    logic row_last;
    logic [C_PIXEL_WIDTH-1:0] seq_word;

    // Only the rdy matching the held word's tag matters.
    assign transfer = dv_q && (seq_tag_q ? seq_datain_rdy : pixel_datain_rdy);
    assign fetch_st = (state_q == ST_SEQ) || (state_q == ST_PIX);
    // Gated by rst so a reset edge never consumes a source word.
    assign src_rden = !rst && fetch_st && (!dv_q || transfer);
    assign pop      = src_rden && src_valid;

    assign seq_last = (seq_cnt_q == seq_len_q - 1'b1);
    assign col_last = (col_cnt_q == cols_q - 1'b1);
    assign row_last = (row_cnt_q == rows_q - 1'b1);
    assign seq_word = C_PIXEL_WIDTH'(src_data[C_SEQ_DATA_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            seq_len_q <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            pix_nz_q  <= 1'b0;
            seq_cnt_q <= '0;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            datain_q  <= '0;
            dv_q      <= 1'b0;
            seq_tag_q <= 1'b0;
            pix_tag_q <= 1'b0;
        end else begin
            if (pop) begin
                datain_q  <= (state_q == ST_SEQ) ? seq_word : src_data;
                dv_q      <= 1'b1;
                seq_tag_q <= (state_q == ST_SEQ);
                pix_tag_q <= (state_q == ST_PIX);
            end else if (transfer) begin
                dv_q      <= 1'b0;
                seq_tag_q <= 1'b0;
                pix_tag_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        seq_len_q <= cmd_seq_len;
                        rows_q    <= cmd_num_rows;
                        cols_q    <= cmd_num_cols;
                        pix_nz_q  <= (cmd_num_rows != '0) && (cmd_num_cols != '0);
                        seq_cnt_q <= '0;
                        row_cnt_q <= '0;
                        col_cnt_q <= '0;
                        if (cmd_seq_len != '0)
                            state_q <= ST_SEQ;
                        else if ((cmd_num_rows != '0) && (cmd_num_cols != '0))
                            state_q <= ST_PIX;
                        else
                            state_q <= ST_DONE;
                    end
                end
                ST_SEQ: begin
                    if (pop) begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                        if (seq_last)
                            state_q <= pix_nz_q ? ST_PIX : ST_DRAIN;
                    end
                end
                ST_PIX: begin
                    if (pop) begin
                        if (col_last) begin
                            col_cnt_q <= '0;
                            if (row_last)
                                state_q <= ST_DRAIN;
                            else
                                row_cnt_q <= row_cnt_q + 1'b1;
                        end else begin
                            col_cnt_q <= col_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!dv_q || transfer)
                        state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_rdy          = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign datain           = datain_q;
    assign datain_valid     = dv_q;
    assign seq_datain_tag   = seq_tag_q;
    assign pixel_datain_tag = pix_tag_q;

endmodule

// File: tb/tb_cnn_layer_accel_octo_streamer.sv
// Directed bench: FWFT source model, capture of every octo transfer, hand-computed expectations.
module tb_cnn_layer_accel_octo_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_rdy;
    logic [12:0] cmd_seq_len;
    logic [8:0]  cmd_num_rows;
    logic [8:0]  cmd_num_cols;
    logic [17:0] src_data;
    logic        src_valid;
    logic        src_rden;
    logic [17:0] datain;
    logic        datain_valid;
    logic        seq_datain_tag;
    logic        pixel_datain_tag;
    logic        seq_datain_rdy;
    logic        pixel_datain_rdy;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    cnn_layer_accel_octo_streamer dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_rdy          (cmd_rdy),
        .cmd_seq_len      (cmd_seq_len),
        .cmd_num_rows     (cmd_num_rows),
        .cmd_num_cols     (cmd_num_cols),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_rden         (src_rden),
        .datain           (datain),
        .datain_valid     (datain_valid),
        .seq_datain_tag   (seq_datain_tag),
        .pixel_datain_tag (pixel_datain_tag),
        .seq_datain_rdy   (seq_datain_rdy),
        .pixel_datain_rdy (pixel_datain_rdy),
        .busy             (busy),
        .done             (done)
    );

    int total = 0;
    int bad   = 0;

    // FWFT source: written by the stimulus, popped by the DUT.
    logic [17:0] src_mem [0:63];
    int          rd_ptr = 0;
    int          n_src  = 0;
    logic        src_en;
    assign src_valid = src_en && (rd_ptr < n_src);
    assign src_data  = src_mem[rd_ptr[5:0]];

    always @(posedge clk)
        if (src_valid && src_rden) rd_ptr <= rd_ptr + 1;

    // Capture of every accepted octo transfer.
    logic [17:0] cap_d [0:255];
    logic        cap_s [0:255];
    logic        cap_p [0:255];
    int          cap_c [0:255];
    int          cap_n    = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && datain_valid && (seq_datain_tag ? seq_datain_rdy : pixel_datain_rdy)) begin
            cap_d[cap_n[7:0]] <= datain;
            cap_s[cap_n[7:0]] <= seq_datain_tag;
            cap_p[cap_n[7:0]] <= pixel_datain_tag;
            cap_c[cap_n[7:0]] <= cyc;
            cap_n             <= cap_n + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Expected transfers for the current command.
    logic [17:0] exp_d [0:15];
    logic        exp_s [0:15];
    int          n_exp = 0;
    int          base_ptr = 0;
    int          cap_start = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic begin_load();
        n_src     = rd_ptr;
        base_ptr  = rd_ptr;
        n_exp     = 0;
        cap_start = cap_n;
    endtask

    task automatic add_src(input logic [17:0] w);
        src_mem[n_src[5:0]] = w;
        n_src++;
    endtask

    task automatic add_exp(input logic [17:0] d, input logic s);
        exp_d[n_exp] = d;
        exp_s[n_exp] = s;
        n_exp++;
    endtask

    task automatic issue(input logic [12:0] sl, input logic [8:0] r, input logic [8:0] c);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_seq_len  = sl;
        cmd_num_rows = r;
        cmd_num_cols = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("done_seen", found, 1'b1);
        @(negedge clk);
        check_val("post_busy", busy, 1'b0);
        check_val("post_cmd_rdy", cmd_rdy, 1'b1);
        check_val("post_done", done, 1'b0);
    endtask

    task automatic check_words(input int cmd_id);
        check_val("word_count", cap_n - cap_start, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            check_val($sformatf("c%0d_w%0d_data", cmd_id, i), cap_d[cap_start + i], exp_d[i]);
            check_val($sformatf("c%0d_w%0d_seqtag", cmd_id, i), cap_s[cap_start + i], exp_s[i]);
            check_val($sformatf("c%0d_w%0d_pixtag", cmd_id, i), cap_p[cap_start + i], !exp_s[i]);
        end
        $display("cmd %0d: %0d words transferred, %0d source pops", cmd_id, cap_n - cap_start, rd_ptr - base_ptr);
    endtask

    initial begin
        int   done_before;
        logic found;

        rst              = 1'b1;
        src_en           = 1'b1;
        cmd_valid        = 1'b0;
        cmd_seq_len      = '0;
        cmd_num_rows     = '0;
        cmd_num_cols     = '0;
        seq_datain_rdy   = 1'b1;
        pixel_datain_rdy = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_cmd_rdy", cmd_rdy, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_dv", datain_valid, 1'b0);
        check_val("rst_datain", datain, 18'h0);
        check_val("rst_seqtag", seq_datain_tag, 1'b0);
        check_val("rst_pixtag", pixel_datain_tag, 1'b0);
        check_val("rst_rden", src_rden, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Cmd 1: 3 seq + 2x2 pixels, all back-to-back; seq masking of 18'h3FFFF
        begin_load();
        add_src(18'h3FFFF); add_exp(18'h01FFF, 1'b1);
        add_src(18'h00ABC); add_exp(18'h00ABC, 1'b1);
        add_src(18'h21234); add_exp(18'h01234, 1'b1);
        add_src(18'h3ABCD); add_exp(18'h3ABCD, 1'b0);
        add_src(18'h00001); add_exp(18'h00001, 1'b0);
        add_src(18'h20000); add_exp(18'h20000, 1'b0);
        add_src(18'h15555); add_exp(18'h15555, 1'b0);
        issue(13'd3, 9'd2, 9'd2);
        check_val("c1_busy", busy, 1'b1);
        check_val("c1_cmd_rdy", cmd_rdy, 1'b0);
        wait_done(40);
        check_words(1);
        for (int i = 1; i < 7; i++)
            check_val($sformatf("c1_consec_%0d", i), cap_c[cap_start + i] - cap_c[cap_start], i);
        check_val("c1_done_lat", done_cyc - cap_c[cap_start + 6], 1);
        check_val("c1_pops", rd_ptr - base_ptr, 7);

        // Cmd 2: same shape, pixel_datain_rdy low for 5 cycles at the first pixel
        begin_load();
        add_src(18'h1FFFF); add_exp(18'h01FFF, 1'b1);
        add_src(18'h0E000); add_exp(18'h00000, 1'b1);
        add_src(18'h00007); add_exp(18'h00007, 1'b1);
        add_src(18'h2AAAA); add_exp(18'h2AAAA, 1'b0);
        add_src(18'h3FFFF); add_exp(18'h3FFFF, 1'b0);
        add_src(18'h00000); add_exp(18'h00000, 1'b0);
        add_src(18'h12345); add_exp(18'h12345, 1'b0);
        pixel_datain_rdy = 1'b0;
        issue(13'd3, 9'd2, 9'd2);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (datain_valid && pixel_datain_tag) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("c2_first_pix_seen", found, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("c2_hold_data_%0d", k), datain, 18'h2AAAA);
            check_val($sformatf("c2_hold_dv_%0d", k), datain_valid, 1'b1);
            check_val($sformatf("c2_hold_tag_%0d", k), {seq_datain_tag, pixel_datain_tag}, 2'b01);
            check_val($sformatf("c2_hold_rden_%0d", k), src_rden, 1'b0);
            @(negedge clk);
        end
        pixel_datain_rdy = 1'b1;
        wait_done(40);
        check_words(2);
        check_val("c2_pops", rd_ptr - base_ptr, 7);

        // Cmd 3: pixels only, source empty for the first few cycles
        begin_load();
        add_src(18'h11111); add_exp(18'h11111, 1'b0);
        add_src(18'h22222); add_exp(18'h22222, 1'b0);
        add_src(18'h33333); add_exp(18'h33333, 1'b0);
        add_src(18'h3C3C3); add_exp(18'h3C3C3, 1'b0);
        src_en = 1'b0;
        done_before = done_cnt;
        issue(13'd0, 9'd1, 9'd4);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("c3_starve_dv_%0d", k), datain_valid, 1'b0);
            check_val($sformatf("c3_starve_busy_%0d", k), busy, 1'b1);
            check_val($sformatf("c3_starve_pops_%0d", k), rd_ptr - base_ptr, 0);
            @(negedge clk);
        end
        src_en = 1'b1;
        wait_done(40);
        check_words(3);
        check_val("c3_done_pulses", done_cnt - done_before, 1);

        // Cmd 4: 2 seq words, no pixels; extra source words must stay unpopped
        begin_load();
        add_src(18'h2FFFF); add_exp(18'h01FFF, 1'b1);
        add_src(18'h04001); add_exp(18'h00001, 1'b1);
        add_src(18'h3FFFF);
        add_src(18'h3FFFF);
        add_src(18'h3FFFF);
        issue(13'd2, 9'd0, 9'd3);
        wait_done(40);
        check_words(4);
        check_val("c4_pops", rd_ptr - base_ptr, 2);
        check_val("c4_rden_idle", src_rden, 1'b0);

        // Cmd 5: reset while pixel word 2 of 4 is on datain
        begin_load();
        add_src(18'h0A0A0);
        add_src(18'h0B0B0);
        add_src(18'h0C0C0);
        add_src(18'h0D0D0);
        done_before = done_cnt;
        issue(13'd0, 9'd1, 9'd4);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (datain_valid && (datain == 18'h0B0B0)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("c5_word2_seen", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_val("c5_rst_dv", datain_valid, 1'b0);
        check_val("c5_rst_busy", busy, 1'b0);
        check_val("c5_rst_cmd_rdy", cmd_rdy, 1'b1);
        check_val("c5_rst_done", done, 1'b0);
        check_val("c5_rst_tags", {seq_datain_tag, pixel_datain_tag}, 2'b00);
        check_val("c5_rst_datain", datain, 18'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("c5_no_done", done_cnt - done_before, 0);
        check_val("c5_pops", rd_ptr - base_ptr, 2);
        check_val("c5_idle_cmd_rdy", cmd_rdy, 1'b1);
        $display("cmd 5: reset after %0d source pops", rd_ptr - base_ptr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
